// File: rtl/accel_job_scheduler_pkg.sv
// Shared types and constants for the accelerator job scheduler.
// Pause codes are {read_pause, write_pause}.
package accel_job_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ENG_FFT = 2'd0;
    localparam logic [1:0] ENG_FIR = 2'd1;
    localparam logic [1:0] ENG_IIR = 2'd2;

    localparam logic [1:0] PAUSE_RD   = 2'b01;
    localparam logic [1:0] PAUSE_WR   = 2'b10;
    localparam logic [1:0] PAUSE_NONE = 2'b11;

    function automatic logic [1:0] next_eng(input logic [1:0] e);
        return (e == ENG_IIR) ? ENG_FFT : e + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin select: first requester at or after rr_ptr,
// in the order fft, fir, iir, wrapping around.
module rr_arbiter3
    import accel_job_scheduler_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] sel,
    output logic [2:0] sel_oh
);

    logic [2:0] sum;
    logic [1:0] idx;

    // Scan farthest-first so the closest requester to rr_ptr wins.
    always_comb begin
        valid  = 1'b0;
        sel    = rr_ptr;
        sel_oh = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 2; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + 3'(i);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
        if (valid) begin
            sel_oh = 3'b001 << sel;
        end
    end

endmodule

// File: rtl/accel_job_scheduler.sv
// Grants one accelerator job at a time and steers the shared address
// bus between the granted engine's read and write address calculators.
module accel_job_scheduler
    import accel_job_scheduler_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int STALL_MAX = 1023,
    parameter int STALL_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] cfg_offset,
    input  logic [ADDR_W-1:0] cfg_filesize,
    input  logic [2:0]        acc_in_ready,
    input  logic [2:0]        acc_out_valid,
    input  logic [2:0]        read_done,
    input  logic [2:0]        write_done,
    output logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] filesize,
    output logic              fft_enable,
    output logic              fir_enable,
    output logic              iir_enable,
    output logic              fft_read_pause,
    output logic              fft_write_pause,
    output logic              fir_read_pause,
    output logic              fir_write_pause,
    output logic              iir_read_pause,
    output logic              iir_write_pause,
    output logic [2:0]        grant,
    output logic              busy,
    output logic [2:0]        job_done,
    output logic [2:0]        job_err
);

    state_e            state_q, state_d;
    logic [1:0]        eng_q, eng_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        enable_q, enable_d;
    logic [2:0][1:0]   pause_q, pause_d;
    logic [2:0]        done_q, done_d;
    logic [2:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              prefer_wr_q, prefer_wr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] filesize_q, filesize_d;

    logic       arb_valid;
    logic [1:0] arb_sel;
    logic [2:0] arb_oh;
    logic       wr_ok, rd_ok;

    rr_arbiter3 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .sel    (arb_sel),
        .sel_oh (arb_oh)
    );

    assign wr_ok = acc_out_valid[eng_q] & ~write_done[eng_q];
    assign rd_ok = acc_in_ready[eng_q] & ~read_done[eng_q];

    always_comb begin
        state_d     = state_q;
        eng_d       = eng_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        enable_d    = enable_q;
        pause_d     = {3{PAUSE_NONE}};
        done_d      = '0;
        err_d       = '0;
        prefer_wr_d = prefer_wr_q;
        stall_d     = stall_q;
        offset_d    = offset_q;
        filesize_d  = filesize_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    eng_d      = arb_sel;
                    grant_d    = arb_oh;
                    enable_d   = arb_oh;
                    offset_d   = cfg_offset;
                    filesize_d = cfg_filesize;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (read_done[eng_q] & write_done[eng_q]) begin
                    state_d  = ST_DONE;
                    enable_d = '0;
                    done_d   = grant_q;
                end else begin
                    if (wr_ok & rd_ok) begin
                        pause_d[eng_q] = prefer_wr_q ? PAUSE_WR : PAUSE_RD;
                        prefer_wr_d    = ~prefer_wr_q;
                    end else if (wr_ok) begin
                        pause_d[eng_q] = PAUSE_WR;
                    end else if (rd_ok) begin
                        pause_d[eng_q] = PAUSE_RD;
                    end
                    if (wr_ok | rd_ok) begin
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                        if (stall_q == STALL_W'(STALL_MAX - 1)) begin
                            state_d  = ST_ERR;
                            enable_d = '0;
                            err_d    = grant_q;
                        end
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                rr_ptr_d = next_eng(eng_q);
                grant_d  = '0;
                stall_d  = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            eng_q       <= ENG_FFT;
            rr_ptr_q    <= ENG_FFT;
            grant_q     <= '0;
            enable_q    <= '0;
            pause_q     <= {3{PAUSE_NONE}};
            done_q      <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            prefer_wr_q <= 1'b0;
            stall_q     <= '0;
            offset_q    <= '0;
            filesize_q  <= '0;
        end else begin
            state_q     <= state_d;
            eng_q       <= eng_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            enable_q    <= enable_d;
            pause_q     <= pause_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            prefer_wr_q <= prefer_wr_d;
            stall_q     <= stall_d;
            offset_q    <= offset_d;
            filesize_q  <= filesize_d;
        end
    end

    assign offset          = offset_q;
    assign filesize        = filesize_q;
    assign grant           = grant_q;
    assign busy            = busy_q;
    assign job_done        = done_q;
    assign job_err         = err_q;
    assign fft_enable      = enable_q[ENG_FFT];
    assign fir_enable      = enable_q[ENG_FIR];
    assign iir_enable      = enable_q[ENG_IIR];
    assign fft_read_pause  = pause_q[ENG_FFT][1];
    assign fft_write_pause = pause_q[ENG_FFT][0];
    assign fir_read_pause  = pause_q[ENG_FIR][1];
    assign fir_write_pause = pause_q[ENG_FIR][0];
    assign iir_read_pause  = pause_q[ENG_IIR][1];
    assign iir_write_pause = pause_q[ENG_IIR][0];

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Directed bench for accel_job_scheduler with hand-computed expectations.
module tb_accel_job_scheduler;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] cfg_offset;
    logic [31:0] cfg_filesize;
    logic [2:0]  in_rdy;
    logic [2:0]  out_vld;
    logic [2:0]  rd_done;
    logic [2:0]  wr_done;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        fft_enable, fir_enable, iir_enable;
    logic        fft_rp, fft_wp, fir_rp, fir_wp, iir_rp, iir_wp;
    logic [2:0]  grant;
    logic        busy;
    logic [2:0]  job_done;
    logic [2:0]  job_err;

    logic [5:0]  pz;
    logic [2:0]  en;
    int          tests;
    int          fails;
    int          n;
    logic [2:0]  rr_exp [4];

    assign pz = {fft_rp, fft_wp, fir_rp, fir_wp, iir_rp, iir_wp};
    assign en = {iir_enable, fir_enable, fft_enable};

    accel_job_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .cfg_offset      (cfg_offset),
        .cfg_filesize    (cfg_filesize),
        .acc_in_ready    (in_rdy),
        .acc_out_valid   (out_vld),
        .read_done       (rd_done),
        .write_done      (wr_done),
        .offset          (offset),
        .filesize        (filesize),
        .fft_enable      (fft_enable),
        .fir_enable      (fir_enable),
        .iir_enable      (iir_enable),
        .fft_read_pause  (fft_rp),
        .fft_write_pause (fft_wp),
        .fir_read_pause  (fir_rp),
        .fir_write_pause (fir_wp),
        .iir_read_pause  (iir_rp),
        .iir_write_pause (iir_wp),
        .grant           (grant),
        .busy            (busy),
        .job_done        (job_done),
        .job_err         (job_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        rst_n = 1'b0;
        req = '0;
        cfg_offset = '0;
        cfg_filesize = '0;
        in_rdy = '0;
        out_vld = '0;
        rd_done = '0;
        wr_done = '0;

        // power-on reset
        tick();
        chk("rst_pause", pz, 6'h3F);
        chk("rst_en", en, 3'b000);
        chk("rst_grant", grant, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", job_done, 3'b000);
        chk("rst_err", job_err, 3'b000);
        chk("rst_offset", offset, 32'h0);
        chk("rst_fsize", filesize, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);

        // FFT read-only job, then writes after read_done
        req = 3'b001;
        cfg_offset = 32'h100;
        cfg_filesize = 32'd4;
        in_rdy = 3'b001;
        tick();
        chk("fft_load_grant", grant, 3'b001);
        chk("fft_load_busy", busy, 1'b1);
        chk("fft_load_off", offset, 32'h100);
        chk("fft_load_fs", filesize, 32'd4);
        chk("fft_load_en", en, 3'b001);
        chk("fft_load_pz", pz, 6'h3F);
        cfg_offset = 32'hDEAD;
        cfg_filesize = 32'd9;
        tick();
        chk("fft_run0_pz", pz, 6'h3F);
        rd_done = 3'b010;
        wr_done = 3'b010;
        tick();
        chk("fft_rd1_pz", pz, 6'h1F);
        chk("fft_off_held", offset, 32'h100);
        tick();
        chk("fft_rd2_pz", pz, 6'h1F);
        chk("fir_done_ign", job_done, 3'b000);
        chk("fir_done_busy", busy, 1'b1);
        rd_done = 3'b001;
        wr_done = 3'b000;
        out_vld = 3'b001;
        tick();
        chk("fft_wr_pz", pz, 6'h2F);
        out_vld = 3'b000;
        tick();
        chk("fft_idle_pz", pz, 6'h3F);
        chk("fft_en_run", en, 3'b001);
        wr_done = 3'b001;
        tick();
        chk("fft_done", job_done, 3'b001);
        chk("fft_done_en", en, 3'b000);
        chk("fft_done_pz", pz, 6'h3F);
        req = '0;
        rd_done = '0;
        wr_done = '0;
        in_rdy = '0;
        tick();
        chk("fft_done_pulse", job_done, 3'b000);
        chk("fft_end_grant", grant, 3'b000);
        chk("fft_end_busy", busy, 1'b0);

        // FIR with both directions ready: alternate read/write
        req = 3'b111;
        in_rdy = 3'b111;
        out_vld = 3'b111;
        tick();
        chk("fir_grant", grant, 3'b010);
        chk("fir_en", en, 3'b010);
        tick();
        chk("fir_run0_pz", pz, 6'h3F);
        tick();
        chk("fir_alt0", pz, 6'h37);
        tick();
        chk("fir_alt1", pz, 6'h3B);
        tick();
        chk("fir_alt2", pz, 6'h37);
        tick();
        chk("fir_alt3", pz, 6'h3B);

        // asynchronous reset mid-RUN, 1 ns wide
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pz", pz, 6'h3F);
        chk("arst_en", en, 3'b000);
        chk("arst_grant", grant, 3'b000);
        chk("arst_busy", busy, 1'b0);
        req = '0;
        in_rdy = '0;
        out_vld = '0;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", busy, 1'b0);

        // round robin from fft after reset
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", grant, rr_exp[k]);
            chk("rr_en", en, rr_exp[k]);
            tick();
            rd_done = rr_exp[k];
            wr_done = rr_exp[k];
            tick();
            chk("rr_done", job_done, rr_exp[k]);
            rd_done = '0;
            wr_done = '0;
            tick();
            chk("rr_pulse", job_done, 3'b000);
            chk("rr_idle", busy, 1'b0);
        end
        req = '0;

        // IIR stall abort
        req = 3'b100;
        tick();
        chk("iir_grant", grant, 3'b100);
        chk("iir_en", en, 3'b100);
        n = 0;
        while (job_err === 3'b000 && n < 1100) begin
            tick();
            n++;
        end
        chk("iir_stall_cyc", n, 1024);
        chk("iir_err", job_err, 3'b100);
        chk("iir_err_en", en, 3'b000);
        chk("iir_err_pz", pz, 6'h3F);
        chk("iir_err_done", job_done, 3'b000);
        req = '0;
        tick();
        chk("iir_err_pulse", job_err, 3'b000);
        chk("iir_end_busy", busy, 1'b0);
        chk("iir_end_grant", grant, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accel_job_scheduler.md
Name: accel_job_scheduler

Overview:
Controller for the shared RAM address-calculation line. Accepts job requests from the FFT, FIR and IIR accelerators and grants one job at a time, round-robin. For the granted engine it drives the enable and the read/write pause signals of the address calculators, so that exactly one address stream (read or write) owns the shared address bus in any cycle. It reports job completion and stall errors to the host sequencer.

Parameters:
ADDR_W, 32, width of offset/filesize.
STALL_MAX, 1023, maximum consecutive RUN cycles with no read or write issued before the job is aborted.
STALL_W, 10, width of the stall counter; must hold STALL_MAX.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  3  job request, one bit per engine {iir,fir,fft}; level, held until matching job_done/job_err.
cfg_offset  in  ADDR_W  RAM base address for the job; sampled at grant.
cfg_filesize  in  ADDR_W  job length; sampled at grant.
acc_in_ready  in  3  engine can accept one read word this cycle.
acc_out_valid  in  3  engine has one result word to write this cycle.
read_done  in  3  read address calculator of that engine finished.
write_done  in  3  write address calculator of that engine finished.
offset  out  ADDR_W  latched offset to the address calculators.
filesize  out  ADDR_W  latched filesize to the address calculators.
fft_enable, fir_enable, iir_enable  out  1 each  engine enable; at most one high.
fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause, iir_read_pause, iir_write_pause  out  1 each  pause to each address calculator.
grant  out  3  one-hot granted engine; 0 when idle.
busy  out  1  high in any state other than IDLE.
job_done  out  3  one-cycle pulse on normal completion.
job_err  out  3  one-cycle pulse on stall abort.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all enables 0; all pauses 1; grant, job_done, job_err = 0; busy 0; offset and filesize 0; rr_ptr = fft; prefer_wr = 0; stall counter 0. All outputs are registered.
- Invariant: for every engine, {read_pause, write_pause} is never 2'b00. Non-granted engines hold 2'b11.
- IDLE: if req != 0, select the first requesting engine at or after rr_ptr in the order fft, fir, iir, wrapping around. Latch cfg_offset/cfg_filesize and set grant, then go to LOAD. If req == 0, stay in IDLE.
- LOAD (1 cycle): assert enable of the granted engine with both pauses 1, so the calculators initialize from offset. Go to RUN.
- RUN, per cycle, using inputs for granted engine g:
  - wr_ok = acc_out_valid[g] & !write_done[g]; rd_ok = acc_in_ready[g] & !read_done[g].
  - Both ok: pick write if prefer_wr, else read; toggle prefer_wr.
  - Only one ok: pick that direction.
  - Neither ok: pauses 2'b11.
  - The chosen direction gets pause 0 in the next cycle (1-cycle latency from inputs to pause).
  - Any issue clears the stall counter; otherwise the counter increments.
  - read_done[g] & write_done[g] both high: go to DONE, pauses 11.
  - Stall counter reaches STALL_MAX: go to ERR.
- DONE / ERR (1 cycle): enable 0, pauses 11, pulse job_done[g] or job_err[g], set rr_ptr to the engine after g, clear grant, clear the stall counter. Go to IDLE.
- req[g] deasserted mid-job is ignored; the job runs to DONE/ERR. Changes to req from other engines are only considered in IDLE.
- read_done before write_done: only writes are issued from then on. Done inputs from non-granted engines are ignored.
- filesize==0 is passed through unmodified; the calculators raise done and the job completes via DONE.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, RUN, DONE, ERR), engine index constants (ENG_FFT=0, ENG_FIR=1, ENG_IIR=2), the pause-code constants PAUSE_RD=2'b01, PAUSE_WR=2'b10, PAUSE_NONE=2'b11.
- One sub-module: rr_arbiter3 (3-way round-robin pointer plus one-hot select, purely combinational given rr_ptr). The FSM, stall counter and direction logic live in the top.

Test Plan:
- Reset mid-RUN of FIR (rst_n low for 1 ns, asynchronous to clk) -> all pauses 1 and enables 0 immediately; grant=0; busy=0.
- req=3'b001, offset=0x100, filesize=4, acc_in_ready=1, acc_out_valid=0 until read_done -> fft_enable high from LOAD; fft pauses alternate only between 01 and 11; job_done=001 one cycle after both dones.
- req=3'b111 held, each job completes -> grants in order fft, fir, iir, fft; each job_done pulse is exactly 1 cycle.
- During RUN, acc_in_ready=acc_out_valid=1 continuously -> pause pairs alternate 01/10 every cycle; never 00.
- Granted IIR with acc_in_ready=acc_out_valid=0 for STALL_MAX cycles -> job_err=100 pulse, iir_enable drops, return to IDLE.
- Assert read_done[fir] and write_done[fir] while FFT is granted -> ignored; FFT job continues unaffected.
